// File: rtl/hilo_unit.sv
// HI/LO register unit: issues multiplies to an external unsigned multiplier,
// fixes up the sign of the product, and writes or accumulates it into HI/LO.
module hilo_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_c
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [1:0] KIND_SET = 2'd0;
  localparam logic [1:0] KIND_ADD = 2'd1;
  localparam logic [1:0] KIND_SUB = 2'd2;

  logic [0:0]  state_r;
  logic        sign_r;
  logic [1:0]  kind_r;
  logic        is_mul_s;
  logic        is_signed_s;
  logic [1:0]  kind_s;
  logic        launch_s;
  logic        wb_s;
  logic [63:0] prod_s;
  logic [63:0] wb_val_s;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  // Decode the opcode into multiply class, signedness and writeback kind
  always_comb begin
    is_mul_s    = 1'b0;
    is_signed_s = 1'b0;
    kind_s      = KIND_SET;
    case (op)
      OP_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; kind_s = KIND_SET; end
      OP_MULTU: begin is_mul_s = 1'b1; is_signed_s = 1'b0; kind_s = KIND_SET; end
      OP_MADD:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; kind_s = KIND_ADD; end
      OP_MADDU: begin is_mul_s = 1'b1; is_signed_s = 1'b0; kind_s = KIND_ADD; end
      OP_MSUB:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; kind_s = KIND_SUB; end
      OP_MSUBU: begin is_mul_s = 1'b1; is_signed_s = 1'b0; kind_s = KIND_SUB; end
      default:  begin is_mul_s = 1'b0; is_signed_s = 1'b0; kind_s = KIND_SET; end
    endcase
  end

  // resetn gates the launch so the request outputs drop to zero asynchronously
  assign launch_s = resetn & (state_r == ST_IDLE) & op_valid & is_mul_s & ~flush;
  assign wb_s     = (state_r == ST_WAIT) & mul_done & ~flush;
  assign prod_s   = sign_r ? (64'd0 - mul_c) : mul_c;

  // Multiplier request and pipeline stall, valid only in the launch cycle
  always_comb begin
    busy      = 1'b0;
    mul_valid = 1'b0;
    mul_a     = 32'd0;
    mul_b     = 32'd0;
    if (launch_s) begin
      busy      = 1'b1;
      mul_valid = 1'b1;
      mul_a     = is_signed_s ? abs32(a) : a;
      mul_b     = is_signed_s ? abs32(b) : b;
    end else begin
      busy      = 1'b0;
      mul_valid = 1'b0;
      mul_a     = 32'd0;
      mul_b     = 32'd0;
    end
  end

  // Combine the signed product with the current HI/LO
  always_comb begin
    wb_val_s = prod_s;
    case (kind_r)
      KIND_SET: wb_val_s = prod_s;
      KIND_ADD: wb_val_s = {hi, lo} + prod_s;
      KIND_SUB: wb_val_s = {hi, lo} - prod_s;
      default:  wb_val_s = prod_s;
    endcase
  end

  // State machine plus HI/LO architectural registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      sign_r  <= 1'b0;
      kind_r  <= KIND_SET;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_r <= ST_WAIT;
            sign_r  <= is_signed_s & (a[31] ^ b[31]);
            kind_r  <= kind_s;
          end else if (op_valid && !flush && op == OP_MTHI) begin
            hi <= a;
          end else if (op_valid && !flush && op == OP_MTLO) begin
            lo <= a;
          end
        end
        ST_WAIT: begin
          state_r <= ST_IDLE;
          if (wb_s) begin
            hi <= wb_val_s[63:32];
            lo <= wb_val_s[31:0];
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed, table-driven bench for hilo_unit with a one-cycle multiplier model.
module tb_hilo_unit;

  logic        clk;
  logic        resetn;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_c;
  logic        kill_done;

  int total;
  int bad;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mv;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [17];

  hilo_unit dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo), .mul_valid(mul_valid),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered multiplier: product and done appear the cycle after the request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_done <= 1'b0;
      mul_c    <= 64'd0;
    end else begin
      mul_done <= mul_valid & ~kill_done;
      mul_c    <= {32'd0, mul_a} * {32'd0, mul_b};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; if it launches, sit through the WAIT cycle
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic fl, input logic fw, input logic emv,
                       input logic [31:0] ema, input logic [31:0] emb);
    op_valid = 1'b1; op = o; a = x; b = y; flush = fl;
    #1;
    chk("launch_mul_valid", {63'd0, mul_valid}, {63'd0, emv});
    chk("launch_busy", {63'd0, busy}, {63'd0, emv});
    chk("launch_mul_a", {32'd0, mul_a}, {32'd0, ema});
    chk("launch_mul_b", {32'd0, mul_b}, {32'd0, emb});
    step();
    flush = 1'b0;
    if (emv) begin
      op = 4'd7; a = 32'hDEAD0000; flush = fw;
      #1;
      chk("wait_busy", {63'd0, busy}, 64'd0);
      chk("wait_mul_valid", {63'd0, mul_valid}, 64'd0);
      step();
      flush = 1'b0;
    end
    op_valid = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
  endtask

  task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk(name, {hi, lo}, {eh, el});
  endtask

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; op_valid = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    flush = 1'b0; kill_done = 1'b0;

    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        1'b1, 32'd2,        32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{4'd1, 32'h80000000, 32'h80000000, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{4'd7, 32'h00000000, 32'd0,        1'b0, 32'd0,        32'd0,        32'h00000000, 32'h00000000};
    vecs[4]  = '{4'd8, 32'hFFFFFFFF, 32'd0,        1'b0, 32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF};
    vecs[5]  = '{4'd3, 32'd1,        32'd1,        1'b1, 32'd1,        32'd1,        32'h00000001, 32'h00000000};
    vecs[6]  = '{4'd5, 32'd1,        32'd1,        1'b1, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF};
    vecs[7]  = '{4'd8, 32'h00000000, 32'd0,        1'b0, 32'd0,        32'd0,        32'h00000000, 32'h00000000};
    vecs[8]  = '{4'd6, 32'hFFFFFFFF, 32'd1,        1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h00000001};
    vecs[9]  = '{4'd0, 32'h00000123, 32'd4,        1'b0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h00000001};
    vecs[10] = '{4'd9, 32'h00000123, 32'd4,        1'b0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h00000001};
    vecs[11] = '{4'd15, 32'h00000123, 32'd4,       1'b0, 32'd0,        32'd0,        32'hFFFFFFFF, 32'h00000001};
    vecs[12] = '{4'd1, 32'hFFFFFFFD, 32'd5,        1'b1, 32'd3,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[13] = '{4'd4, 32'd2,        32'd2,        1'b1, 32'd2,        32'd2,        32'hFFFFFFFF, 32'hFFFFFFF5};
    vecs[14] = '{4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFF4};
    vecs[15] = '{4'd3, 32'd7,        32'hFFFFFFFE, 1'b1, 32'd7,        32'd2,        32'hFFFFFFFF, 32'hFFFFFFE6};
    vecs[16] = '{4'd7, 32'h12345678, 32'd0,        1'b0, 32'd0,        32'd0,        32'h12345678, 32'hFFFFFFE6};

    #1;
    chk_hilo("reset_hilo", 32'd0, 32'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_mul_valid", {63'd0, mul_valid}, 64'd0);
    step();
    step();
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, vecs[i].mv, vecs[i].ma, vecs[i].mb);
      chk_hilo($sformatf("vec%0d_hilo", i), vecs[i].hi, vecs[i].lo);
    end

    // Flush in WAIT keeps HI/LO, and the unit is IDLE right after
    issue(4'd7, 32'h11, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    issue(4'd8, 32'h22, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    issue(4'd1, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 32'd5, 32'd7);
    chk_hilo("flush_wait_hilo", 32'h11, 32'h22);
    issue(4'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b1, 32'd2, 32'd3);
    chk_hilo("after_flush_mult", 32'd0, 32'd6);

    // Flush in the launch cycle: no request, no stall, no write
    issue(4'd1, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk_hilo("flush_launch_hilo", 32'd0, 32'd6);
    issue(4'd8, 32'h99, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk_hilo("flush_mtlo_hilo", 32'd0, 32'd6);

    // Missing mul_done: writeback dropped
    kill_done = 1'b1;
    issue(4'd2, 32'd100, 32'd100, 1'b0, 1'b0, 1'b1, 32'd100, 32'd100);
    kill_done = 1'b0;
    chk_hilo("no_done_hilo", 32'd0, 32'd6);

    // Back-to-back MULTU then MADDU, each with its own stall
    issue(4'd2, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 32'd3, 32'd4);
    chk_hilo("b2b_multu", 32'd0, 32'h0C);
    issue(4'd4, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, 32'd2, 32'd2);
    chk_hilo("b2b_maddu", 32'd0, 32'h10);

    // Reset asserted during WAIT of MULT 9*9
    issue(4'd7, 32'hAB, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    op_valid = 1'b1; op = 4'd1; a = 32'd9; b = 32'd9;
    #1;
    chk("rst_launch_mul_valid", {63'd0, mul_valid}, 64'd1);
    step();
    resetn = 1'b0;
    #1;
    chk_hilo("rst_async_hilo", 32'd0, 32'd0);
    chk("rst_async_busy", {63'd0, busy}, 64'd0);
    chk("rst_async_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_async_mul_ab", {mul_a, mul_b}, 64'd0);
    step();
    step();
    resetn = 1'b1;
    op = 4'd8; a = 32'h55;
    step();
    op_valid = 1'b0; op = 4'd0;
    chk_hilo("post_rst_mtlo", 32'd0, 32'h55);
    step();
    step();
    step();
    chk_hilo("post_rst_no_late_write", 32'd0, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
